// File: rtl/uparc_alu_mdu_if.sv
// Request/response bundle between the execute stage and the ALU/MDU.
// master = issuing pipeline, slave = uparc_alu_mdu.
interface uparc_alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_lo;
  logic [WIDTH-1:0] resp_hi;
  logic             resp_ovflow;
  logic             resp_zero;
  logic             resp_neg;
  logic             resp_divz;

  modport master (
    output flush, req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_lo, resp_hi,
           resp_ovflow, resp_zero, resp_neg, resp_divz
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_lo, resp_hi,
           resp_ovflow, resp_zero, resp_neg, resp_divz
  );
endinterface

// File: rtl/uparc_alu_mdu.sv
// ALU with iterative multiply/divide; registered hi/lo result plus flags.
// Latency: 1 cycle for logic/arith ops, WIDTH+1 cycles for MULT/MULTU/DIV/DIVU.
// Backpressure: one op in flight; req_ready only in IDLE, result held until resp_ready.
module uparc_alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int CNTW  = 6
) (
  input  logic           clk,
  input  logic           nrst,
  uparc_alu_mdu_if.slave bus
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_SRA   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi_r, lo_r, opb_r;
  logic [CNTW-1:0]  cnt_r;
  logic             is_div_r, sgn_q_r, sgn_rem_r;
  logic             res_ovflow, res_zero, res_neg, res_divz;

  logic [WIDTH-1:0] a, b;
  logic [3:0]       op;
  logic             accept, is_iter, is_signed, op_div;

  assign a         = bus.req_a;
  assign b         = bus.req_b;
  assign op        = bus.req_op;
  assign accept    = bus.req_valid && bus.req_ready && !bus.flush;
  assign is_iter   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = is_iter ? CALC : RESP;
        CALC: if (cnt_r == CNTW'(1)) state_nxt = RESP;
        RESP: if (bus.resp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = nrst && (state == IDLE);
    bus.resp_valid = (state == RESP);
  end

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] alu_lo, sum, dif;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign dif   = a - b;

  always_comb begin
    alu_lo  = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_lo  = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo  = dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_lo = a << shamt;
      OP_SRL:  alu_lo = a >> shamt;
      OP_SRA:  alu_lo = $signed(a) >>> shamt;
      OP_AND:  alu_lo = a & b;
      OP_OR:   alu_lo = a | b;
      OP_XOR:  alu_lo = a ^ b;
      OP_NOR:  alu_lo = ~(a | b);
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_lo = '0;
    endcase
  end

  // ---------------- iterative mul/div step ----------------
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_t;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, div_dif;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;

  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add: low half holds the remaining multiplier bits, shifted out LSB-first.
  assign mul_sum = {1'b0, hi_r} + {1'b0, (lo_r[0] ? opb_r : '0)};
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_r[WIDTH-1:1]};

  // Restoring divide: remainder < divisor, so the difference always fits in WIDTH bits.
  assign div_t   = {hi_r, lo_r[WIDTH-1]};
  assign div_ge  = div_t >= {1'b0, opb_r};
  assign div_dif = div_t[WIDTH-1:0] - opb_r;
  assign div_hi  = div_ge ? div_dif : div_t[WIDTH-1:0];
  assign div_lo  = {lo_r[WIDTH-2:0], div_ge};

  assign prod     = {mul_hi, mul_lo};
  assign prod_fix = sgn_q_r ? -prod : prod;

  always_comb begin
    step_hi = is_div_r ? div_hi : mul_hi;
    step_lo = is_div_r ? div_lo : mul_lo;
    if (is_div_r) begin
      fin_lo = res_divz ? '1 : (sgn_q_r ? -div_lo : div_lo);
      fin_hi = sgn_rem_r ? -div_hi : div_hi;
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hi_r       <= '0;
      lo_r       <= '0;
      opb_r      <= '0;
      cnt_r      <= '0;
      is_div_r   <= 1'b0;
      sgn_q_r    <= 1'b0;
      sgn_rem_r  <= 1'b0;
      res_ovflow <= 1'b0;
      res_zero   <= 1'b0;
      res_neg    <= 1'b0;
      res_divz   <= 1'b0;
    end else if (bus.flush) begin
      cnt_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          res_ovflow <= is_iter ? 1'b0 : alu_ovf;
          if (is_iter) begin
            cnt_r      <= CNTW'(WIDTH);
            hi_r       <= '0;
            lo_r       <= mag_a;
            opb_r      <= mag_b;
            is_div_r   <= op_div;
            sgn_q_r    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_rem_r  <= is_signed && a[WIDTH-1];
            res_divz   <= op_div && (b == '0);
          end else begin
            hi_r       <= '0;
            lo_r       <= alu_lo;
            res_zero   <= (alu_lo == '0);
            res_neg    <= alu_lo[WIDTH-1];
            res_divz   <= 1'b0;
          end
        end
        CALC: begin
          cnt_r <= cnt_r - CNTW'(1);
          if (cnt_r == CNTW'(1)) begin
            hi_r     <= fin_hi;
            lo_r     <= fin_lo;
            res_zero <= (fin_lo == '0);
            res_neg  <= fin_lo[WIDTH-1];
          end else begin
            hi_r <= step_hi;
            lo_r <= step_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_lo     = lo_r;
  assign bus.resp_hi     = hi_r;
  assign bus.resp_ovflow = res_ovflow;
  assign bus.resp_zero   = res_zero;
  assign bus.resp_neg    = res_neg;
  assign bus.resp_divz   = res_divz;

endmodule

// File: tb/tb_uparc_alu_mdu.sv
// Directed + random bench for uparc_alu_mdu: expectations from a 64-bit reference model,
// queued at issue and compared when the response handshake occurs.
module tb_uparc_alu_mdu;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  SLL = 4'd2,  SRL = 4'd3;
  localparam logic [3:0] SRA = 4'd4,  AND = 4'd5,  OR_ = 4'd6,  XOR = 4'd7;
  localparam logic [3:0] NOR = 4'd8,  SLT = 4'd9,  SLTU = 4'd10, MULT = 4'd11;
  localparam logic [3:0] MULTU = 4'd12, DIV = 4'd13, DIVU = 4'd14, RSV = 4'd15;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  uparc_alu_mdu_if #(.WIDTH(32)) bus ();

  uparc_alu_mdu #(.WIDTH(32), .SHW(5), .CNTW(6)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        divz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    e.hi = '0; e.lo = '0; e.ovf = 1'b0; e.divz = 1'b0; e.lat = 1;
    case (op)
      ADD:  begin e.lo = a + b; e.ovf = (a[31] == b[31]) && (e.lo[31] != a[31]); end
      SUB:  begin e.lo = a - b; e.ovf = (a[31] != b[31]) && (e.lo[31] != a[31]); end
      SLL:  e.lo = a << b[4:0];
      SRL:  e.lo = a >> b[4:0];
      SRA:  e.lo = $signed(a) >>> b[4:0];
      AND:  e.lo = a & b;
      OR_:  e.lo = a | b;
      XOR:  e.lo = a ^ b;
      NOR:  e.lo = ~(a | b);
      SLT:  e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: e.lo = (a < b) ? 32'd1 : 32'd0;
      MULT: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; end
      MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; end
      DIV, DIVU: begin
        e.lat = 33;
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.divz = 1'b1;
        end else if (op == DIV) begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e.lo = '0;
    endcase
    e.zero = (e.lo == 32'd0);
    e.neg  = e.lo[31];
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int w = 0;
    while (bus.req_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("send_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (push) sb_q.push_back(model(op, a, b));
  endtask

  task automatic receive(input string tag, input int hold);
    int   c = 1;
    bit   rdy_seen = 1'b0;
    exp_t e;
    while (bus.resp_valid !== 1'b1 && c < 100) begin
      if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1; c++;
    end
    if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
    check({tag, "_busy_rdy"}, 64'(rdy_seen), 64'd0);
    check({tag, "_sb"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin e.hi = '0; e.lo = '0; e.ovf = 0; e.zero = 0; e.neg = 0; e.divz = 0; e.lat = 0; end
    check({tag, "_lat"},  64'(c), 64'(e.lat));
    check({tag, "_hi"},   64'(bus.resp_hi), 64'(e.hi));
    check({tag, "_lo"},   64'(bus.resp_lo), 64'(e.lo));
    check({tag, "_ovf"},  64'(bus.resp_ovflow), 64'(e.ovf));
    check({tag, "_zero"}, 64'(bus.resp_zero), 64'(e.zero));
    check({tag, "_neg"},  64'(bus.resp_neg), 64'(e.neg));
    check({tag, "_divz"}, 64'(bus.resp_divz), 64'(e.divz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hold_rdy"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_hold_hilo"}, {bus.resp_hi, bus.resp_lo}, {e.hi, e.lo});
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, "_post_vld"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    send(op, a, b, 1'b1);
    receive(tag, 0);
  endtask

  task automatic no_resp(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.resp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = '0;
    bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_hilo", {bus.resp_hi, bus.resp_lo}, 64'd0);
    check("rst_flags", 64'({bus.resp_ovflow, bus.resp_zero, bus.resp_neg, bus.resp_divz}), 64'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);

    run(ADD,  32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
    run(SUB,  32'd5, 32'd5, "sub_zero");
    run(SUB,  32'h8000_0000, 32'd1, "sub_ovf");
    run(NOR,  32'h0F0F_0000, 32'h0000_0F0F, "nor");
    run(SRA,  32'h8000_0000, 32'd4, "sra");
    run(SRL,  32'h8000_0000, 32'h0000_0024, "srl_mask");
    run(SLL,  32'h0000_0001, 32'd31, "sll");
    run(SLTU, 32'd1, 32'hFFFF_FFFF, "sltu");
    run(SLT,  32'd1, 32'hFFFF_FFFF, "slt");
    run(XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, "xor");
    run(RSV,  32'h1234_5678, 32'h9ABC_DEF0, "rsv");
    run(MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run(DIV,  32'hFFFF_FFF9, 32'd2, "div_neg");
    run(DIVU, 32'd7, 32'd0, "divu_zero");
    run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_minneg1");
    run(DIV,  32'h8000_0000, 32'd0, "div_zero_neg");
    run(DIV,  32'd100, 32'hFFFF_FFF9, "div_posneg");

    // Consumer stall: result held for 5 cycles, then released.
    send(ADD, 32'd3, 32'd4, 1'b1);
    receive("stall", 5);
    run(OR_, 32'hF000_0000, 32'h0000_000F, "after_stall");

    // Flush in the middle of a multiply.
    send(MULT, 32'd123, 32'd456, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_vld", 64'(bus.resp_valid), 64'd0);
    check("flush_rdy", 64'(bus.req_ready), 64'd1);
    no_resp("flush_no_resp", 40);

    // A request coinciding with flush must be dropped.
    bus.req_valid = 1'b1; bus.req_op = ADD; bus.req_a = 32'd1; bus.req_b = 32'd1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush_req_vld", 64'(bus.resp_valid), 64'd0);
    check("flush_req_rdy", 64'(bus.req_ready), 64'd1);
    run(ADD, 32'd10, 32'hFFFF_FFFF, "after_flush");

    // Reset in the middle of a divide.
    send(DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("arst_rdy", 64'(bus.req_ready), 64'd0);
    check("arst_vld", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_rdy", 64'(bus.req_ready), 64'd1);
    no_resp("arst_no_resp", 40);
    run(ADD, 32'h0000_FFFF, 32'h0000_0001, "after_rst");

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      run(rop, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uparc_alu_mdu.md
Name: uparc_alu_mdu

Overview:
- Parametrised, handshaked successor to the CPU's single-cycle ALU.
- Adds iterative multiply and divide (signed and unsigned), a registered result with valid/ready handshake, a synchronous flush, and a configurable datapath width.
- Sits in the execute stage. The pipeline issues one operation at a time and stalls on req_ready low.
- Produces a 2*WIDTH result as hi/lo plus flags.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a power of 2, at least 8.
- SHW, 5: shift-amount width; equals log2(WIDTH).
- CNTW, 6: iteration-counter width; equals log2(WIDTH)+1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous cancel of any in-flight operation.
- req_valid  in  1  operation request.
- req_ready  out  1  block can accept a request.
- req_op  in  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 reserved.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B. Shifts use b[SHW-1:0] as the shift amount.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_lo  out  WIDTH  result; product low half, or quotient.
- resp_hi  out  WIDTH  product high half, or remainder; 0 for single-cycle ops.
- resp_ovflow  out  1  signed overflow; ADD and SUB only.
- resp_zero  out  1  resp_lo == 0.
- resp_neg  out  1  resp_lo[WIDTH-1].
- resp_divz  out  1  DIV or DIVU with b == 0.

Behaviour:
- Reset (nrst low, asynchronous): state IDLE, counter 0, all resp_* outputs 0, req_ready 0 while nrst is low.
- FSM states: IDLE, CALC, RESP. req_ready = (state == IDLE). resp_valid = (state == RESP).
- IDLE, on req_valid and req_ready:
  - Opcodes 0-10 and 15: compute combinationally, register into resp_*, go to RESP. resp_valid is high on the next cycle (latency 1).
  - Opcodes 11-14: latch operand magnitudes and result sign, counter = WIDTH, go to CALC.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. Counter decrements each step.
  - When counter reaches 1, the final step completes and state goes to RESP with sign correction applied.
  - resp_valid rises exactly WIDTH+1 cycles after acceptance.
- RESP: resp_* held stable. On resp_ready, go to IDLE. Back-to-back throughput is one single-cycle op per 2 cycles.
- flush: highest priority after reset. From any state, go to IDLE next cycle and clear resp_valid; resp_* data is don't-care. A request presented in the same cycle as flush is not accepted.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH. ovflow = operand signs equal (A vs B for ADD, A vs ~B for SUB) and result sign differs from A.
  - NOR is bitwise ~(a|b).
  - SRA sign-extends.
  - SLT/SLTU return 1 or 0 in resp_lo.
  - Opcode 15 returns all zeros.
  - resp_ovflow is 0 for every opcode other than ADD and SUB.
- MULT/MULTU: {hi,lo} is the full 2*WIDTH product. Signed multiply is computed on magnitudes, then negated in 2*WIDTH if the operand signs differ.
- DIV/DIVU:
  - lo = quotient truncated toward zero; hi = remainder, carrying the sign of A.
  - Divide by zero: lo = all ones, hi = A, resp_divz = 1. The full WIDTH iterations still run.
  - Signed most-negative / -1: lo = most-negative value, hi = 0, resp_ovflow stays 0.
- resp_zero and resp_neg always reflect resp_lo, including for mul/div results.
- Reset asserted mid-CALC aborts immediately. After release, the block is in IDLE with no response pending.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> resp_lo 0x80000000, ovflow 1, neg 1, resp_valid 1 cycle after accept. SUB 5-5 -> lo 0, zero 1.
- NOR 0x0F0F0000, 0x00000F0F -> 0xF0F0F0F0. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1; SLT with the same operands -> 0.
- MULT 0xFFFFFFFE (-2) x 3 -> hi 0xFFFFFFFF, lo 0xFFFFFFFA. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001. resp_valid exactly 33 cycles after accept; req_ready low throughout.
- DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 7/0 -> lo 0xFFFFFFFF, hi 7, divz 1. DIV 0x80000000 / -1 -> lo 0x80000000, hi 0.
- Hold resp_ready low for 5 cycles -> resp_* stable and req_ready 0. Raise resp_ready -> IDLE next cycle, and the next request is accepted.
- Assert flush at CALC cycle 10, then separately drop nrst at CALC cycle 10 -> no resp_valid appears in either case; IDLE with req_ready 1 on the following cycle; a subsequent ADD completes correctly.
